// File: rtl/encoder8x3_serializer_pkg.sv
// Shared constants and state type for the 8->3 request encoder/serializer.
package coder_pkg;
   localparam int DATA_W = 8;
   localparam int CODE_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } coder_state_e;
endpackage

// File: rtl/encoder8x3_serializer_if.sv
// Request capture and code output handshake bundle.
interface encoder8x3_serializer_if;
   import coder_pkg::*;

   logic              req_valid;
   logic [DATA_W-1:0] req_in;
   logic              code_ready;
   logic [CODE_W-1:0] code_out;
   logic              code_valid;

   modport master (
      output req_valid,
      output req_in,
      output code_ready,
      input  code_out,
      input  code_valid
   );

   modport slave (
      input  req_valid,
      input  req_in,
      input  code_ready,
      output code_out,
      output code_valid
   );
endinterface

// File: rtl/encoder8x3_serializer_prio.sv
// Combinational first-set finder over an 8-bit vector, direction by parameter.
module prio_enc8x3
   import coder_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic [DATA_W-1:0] vec,
   output logic [CODE_W-1:0] idx,
   output logic              any
);

   // Later matches overwrite earlier ones, so scan toward the winning end.
   always_comb begin
      idx = '0;
      if (LSB_FIRST) begin
         for (int i = DATA_W - 1; i >= 0; i--) begin
            if (vec[i]) idx = CODE_W'(i);
         end
      end else begin
         for (int i = 0; i < DATA_W; i++) begin
            if (vec[i]) idx = CODE_W'(i);
         end
      end
   end

   assign any = |vec;

endmodule

// File: rtl/encoder8x3_serializer.sv
// Accumulates multi-hot requests and streams one 3-bit index per set bit.
module encoder8x3_serializer
   import coder_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic                     err_clr,
   encoder8x3_serializer_if.slave   ifc,
   output logic [DATA_W-1:0]        pending,
   output logic                     busy,
   output logic                     dup_err
);

   coder_state_e      r_state;
   coder_state_e      w_state_nxt;
   logic [DATA_W-1:0] r_pending;
   logic [CODE_W-1:0] r_code_out;
   logic              r_dup_err;

   logic [CODE_W-1:0] w_sel;
   logic              w_any;
   logic              w_cap;
   logic              w_load;
   logic              w_hs;
   logic [DATA_W-1:0] w_mask;
   logic [DATA_W-1:0] w_cap_vec;
   logic              w_dup;

   prio_enc8x3 #(
      .LSB_FIRST (LSB_FIRST)
   ) u_prio (
      .vec (r_pending),
      .idx (w_sel),
      .any (w_any)
   );

   assign w_cap     = enable & ifc.req_valid;
   assign w_hs      = (r_state == SEND) & ifc.code_ready;
   assign w_load    = enable & w_any &
                      ((r_state == IDLE) | ifc.code_ready);
   assign w_mask    = w_load ? (DATA_W'(1) << w_sel) : '0;
   assign w_cap_vec = w_cap ? ifc.req_in : '0;
   // A re-request of the bit leaving this cycle is a fresh request.
   assign w_dup     = |(w_cap_vec & r_pending & ~w_mask);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: if (w_load) w_state_nxt = SEND;
         SEND: if (w_hs && !w_load) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_pending  <= '0;
         r_code_out <= '0;
         r_dup_err  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= (r_pending & ~w_mask) | w_cap_vec;
         if (w_load) r_code_out <= w_sel;
         if (w_dup) r_dup_err <= 1'b1;
         else if (err_clr) r_dup_err <= 1'b0;
      end
   end

   assign ifc.code_out   = r_code_out;
   assign ifc.code_valid = (r_state == SEND);
   assign pending        = r_pending;
   assign dup_err        = r_dup_err;
   assign busy           = (r_state == SEND) | (|r_pending);

endmodule

// File: tb/tb_encoder8x3_serializer.sv
// Directed table-driven bench for encoder8x3_serializer, both scan orders.
module tb_encoder8x3_serializer;
   import coder_pkg::*;

   logic       clk;
   logic       rst_a;
   logic       rst_b;
   logic       en;
   logic       clr;
   logic       rv;
   logic [7:0] rin;
   logic       rdy;

   logic [7:0] pend_a, pend_b;
   logic       busy_a, busy_b;
   logic       dup_a, dup_b;

   int total = 0;
   int bad   = 0;

   encoder8x3_serializer_if ifa ();
   encoder8x3_serializer_if ifb ();

   assign ifa.req_valid  = rv;
   assign ifa.req_in     = rin;
   assign ifa.code_ready = rdy;
   assign ifb.req_valid  = rv;
   assign ifb.req_in     = rin;
   assign ifb.code_ready = rdy;

   encoder8x3_serializer #(.LSB_FIRST(1'b1)) dut_a (
      .clk     (clk),
      .rst_n   (rst_a),
      .enable  (en),
      .err_clr (clr),
      .ifc     (ifa.slave),
      .pending (pend_a),
      .busy    (busy_a),
      .dup_err (dup_a)
   );

   encoder8x3_serializer #(.LSB_FIRST(1'b0)) dut_b (
      .clk     (clk),
      .rst_n   (rst_b),
      .enable  (en),
      .err_clr (clr),
      .ifc     (ifb.slave),
      .pending (pend_b),
      .busy    (busy_b),
      .dup_err (dup_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       en;
      logic       rv;
      logic [7:0] rin;
      logic       rdy;
      logic       clr;
      logic       v;
      logic [2:0] c;
      logic [7:0] p;
      logic       d;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic e, input logic r, input logic [7:0] ri,
                      input logic rd, input logic cl, input logic v,
                      input logic [2:0] c, input logic [7:0] p,
                      input logic d);
      vec_t t;
      t.en = e; t.rv = r; t.rin = ri; t.rdy = rd; t.clr = cl;
      t.v = v; t.c = c; t.p = p; t.d = d;
      tbl.push_back(t);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_a(input string nm, input logic v, input logic [2:0] c,
                        input logic [7:0] p, input logic d);
      chk({nm, "_valid"}, int'(ifa.code_valid), int'(v));
      chk({nm, "_code"},  int'(ifa.code_out),   int'(c));
      chk({nm, "_pend"},  int'(pend_a),         int'(p));
      chk({nm, "_dup"},   int'(dup_a),          int'(d));
      chk({nm, "_busy"},  int'(busy_a),         int'(v | (|p)));
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      en = 1'b0; clr = 1'b0; rv = 1'b0; rin = 8'h00; rdy = 1'b0;

      // en rv rin rdy clr | valid code pending dup
      add(1,1,8'h04,1,0, 0,0,8'h04,0);
      add(1,0,8'h00,1,0, 1,2,8'h00,0);
      add(1,0,8'h00,1,0, 0,2,8'h00,0);
      add(1,1,8'hA2,1,0, 0,2,8'hA2,0);
      add(1,0,8'h00,1,0, 1,1,8'hA0,0);
      add(1,0,8'h00,1,0, 1,5,8'h80,0);
      add(1,0,8'h00,1,0, 1,7,8'h00,0);
      add(1,0,8'h00,1,0, 0,7,8'h00,0);
      add(1,1,8'h81,0,0, 0,7,8'h81,0);
      add(1,0,8'h00,0,0, 1,0,8'h80,0);
      add(1,0,8'h00,0,0, 1,0,8'h80,0);
      add(1,0,8'h00,0,0, 1,0,8'h80,0);
      add(1,1,8'h80,0,0, 1,0,8'h80,1);
      add(1,0,8'h00,0,0, 1,0,8'h80,1);
      add(1,0,8'h00,1,0, 1,7,8'h00,1);
      add(1,0,8'h00,1,1, 0,7,8'h00,0);
      add(1,1,8'h08,1,0, 0,7,8'h08,0);
      add(1,1,8'h08,1,0, 1,3,8'h08,0);
      add(1,0,8'h00,1,0, 1,3,8'h00,0);
      add(1,0,8'h00,1,0, 0,3,8'h00,0);
      add(1,1,8'h10,0,0, 0,3,8'h10,0);
      add(1,0,8'h00,0,0, 1,4,8'h00,0);
      add(1,1,8'h20,0,0, 1,4,8'h20,0);
      add(1,1,8'h20,0,1, 1,4,8'h20,1);
      add(1,0,8'h00,0,1, 1,4,8'h20,0);
      add(1,0,8'h00,1,0, 1,5,8'h00,0);
      add(1,0,8'h00,1,0, 0,5,8'h00,0);
      add(1,1,8'h06,0,0, 0,5,8'h06,0);
      add(1,0,8'h00,0,0, 1,1,8'h04,0);
      add(0,0,8'h00,0,0, 1,1,8'h04,0);
      add(0,0,8'h00,1,0, 0,1,8'h04,0);
      add(0,0,8'h00,1,0, 0,1,8'h04,0);
      add(0,1,8'h01,1,0, 0,1,8'h04,0);
      add(1,0,8'h00,1,0, 1,2,8'h00,0);
      add(1,0,8'h00,1,0, 0,2,8'h00,0);
      add(1,1,8'h00,1,0, 0,2,8'h00,0);
      add(1,1,8'hFF,1,0, 0,2,8'hFF,0);
      add(1,0,8'h00,1,0, 1,0,8'hFE,0);
      add(1,0,8'h00,1,0, 1,1,8'hFC,0);
      add(1,0,8'h00,1,0, 1,2,8'hF8,0);
      add(1,0,8'h00,1,0, 1,3,8'hF0,0);
      add(1,0,8'h00,1,0, 1,4,8'hE0,0);
      add(1,0,8'h00,1,0, 1,5,8'hC0,0);
      add(1,0,8'h00,1,0, 1,6,8'h80,0);
      add(1,0,8'h00,1,0, 1,7,8'h00,0);
      add(1,0,8'h00,1,0, 0,7,8'h00,0);

      #3 rst_a = 1'b0; rst_b = 1'b0;
      #1 chk_a("reset", 0, 0, 8'h00, 0);
      @(negedge clk);
      rst_a = 1'b1;
      step();
      chk_a("post_reset", 0, 0, 8'h00, 0);

      foreach (tbl[i]) begin
         en = tbl[i].en; rv = tbl[i].rv; rin = tbl[i].rin;
         rdy = tbl[i].rdy; clr = tbl[i].clr;
         step();
         chk_a($sformatf("row%0d", i), tbl[i].v, tbl[i].c, tbl[i].p,
               tbl[i].d);
      end

      // Asynchronous reset in the middle of a full drain.
      en = 1'b1; rv = 1'b1; rin = 8'hFF; rdy = 1'b1; clr = 1'b0;
      step();
      rv = 1'b0; rin = 8'h00;
      step(); step(); step();
      chk_a("burst3", 1, 2, 8'hF8, 0);
      #2 rst_a = 1'b0;
      #1 chk_a("midrst", 0, 0, 8'h00, 0);
      @(negedge clk);
      rst_a = 1'b1;
      step(); step();
      chk_a("after_rst", 0, 0, 8'h00, 0);

      // Highest-first instance.
      rst_b = 1'b1;
      rv = 1'b1; rin = 8'hA2; rdy = 1'b1;
      step();
      chk("msb_pend", int'(pend_b), 'hA2);
      rv = 1'b0; rin = 8'h00;
      step();
      chk("msb_c0", int'(ifb.code_out), 7);
      chk("msb_v0", int'(ifb.code_valid), 1);
      step();
      chk("msb_c1", int'(ifb.code_out), 5);
      chk("msb_p1", int'(pend_b), 'h02);
      step();
      chk("msb_c2", int'(ifb.code_out), 1);
      chk("msb_v2", int'(ifb.code_valid), 1);
      step();
      chk("msb_v3", int'(ifb.code_valid), 0);
      chk("msb_busy", int'(busy_b), 0);
      chk("msb_dup", int'(dup_b), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/encoder8x3_serializer.md
# encoder8x3_serializer

Inverse companion of the 3x8 decoder: accepts 8-bit request vectors, accumulates them in a pending register, and emits one 3-bit binary code per pending bit over a valid/ready handshake, in fixed priority order. It sits where several one-hot or multi-hot request lines must be funnelled into a single encoded index stream, for example feeding a decoder3x8 on the far side of a narrow link.

## Interface
- `LSB_FIRST`, default 1: 1 means the lowest set index is emitted first; 0 means the highest set index is emitted first.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: gates request capture and new code launches.
- `req_valid`, input, 1: capture strobe for `req_in`.
- `req_in`, input, 8: request vector; any number of bits may be set.
- `err_clr`, input, 1: synchronous clear of `dup_err`.
- `code_ready`, input, 1: downstream accepts `code_out`.
- `code_out`, output, 3: encoded index, registered.
- `code_valid`, output, 1: `code_out` is valid, registered.
- `pending`, output, 8: requests captured but not yet loaded into `code_out`.
- `busy`, output, 1: `code_valid | (|pending)`.
- `dup_err`, output, 1: sticky flag; a request arrived for a bit that was already pending.

## Operation
- **Reset:** while `rst_n` is low, `code_out`=3'b000, `code_valid`=0, `pending`=8'h00, `dup_err`=0 and `busy`=0. The reset is asynchronous and takes effect immediately, even mid-operation; any code in flight is dropped.
- **Capture:** `cap` = `enable & req_valid`.
- **Load:** `load` = `enable & (|pending) & (~code_valid | code_ready)`. On a load, `sel` is the first set bit of `pending` in `LSB_FIRST` order, and `load_mask` = one-hot(`sel`).
- **Pending update each edge:** `pending` <= (`pending` & ~(`load` ? `load_mask` : 0)) | (`cap` ? `req_in` : 0). When a bit is loaded and re-requested in the same cycle, the bit stays pending and is treated as a new request.
- **Duplicate detection:**
  - `dup_err` is set when `cap` is true and `req_in` & `pending` & ~`load_mask` is nonzero. A re-request that collides with a bit being loaded in the same cycle is not a duplicate.
  - `err_clr` clears `dup_err`. If a set and a clear occur in the same cycle, the set wins.
- **Output register:**
  - On `load`: `code_out` <= `sel` and `code_valid` <= 1.
  - Else on `code_valid & code_ready`: `code_valid` <= 0, and `code_out` holds its last value.
- **Handshake rules:**
  - While `code_valid=1` and `code_ready=0`, `code_out` is stable.
  - Once asserted, `code_valid` is never withdrawn without a handshake, even if `enable` falls.
- **Enable low:** no capture and no new load. `pending` is retained, and an in-flight code completes normally.
- **State machine, derived from `code_valid`:**
  - IDLE (`code_valid`=0): moves to SEND on `load`.
  - SEND (`code_valid`=1):
    - handshake with `load` → stays in SEND with the next code;
    - handshake without `load` → IDLE;
    - no handshake → stays in SEND.
- **`req_in`=8'h00 with `req_valid`=1:** no effect.

## Timing
- Latency: `req_valid` at edge N, then `pending` updated at N, then `code_valid` at N+1 (2 cycles from request to valid when idle).
- Throughput: one code per cycle while `code_ready`=1 and `pending` is nonzero, with no bubble between codes.
- `pending` can refill on the same edge as a handshake; a full `pending`=8'hFF drains in 8 consecutive cycles.
- `busy` is combinational from registers and is glitch-free relative to `clk`.

## Structure
- **Shared package `coder_pkg`:**
  - `DATA_W`=8 and `CODE_W`=3 constants;
  - the `coder_state_e` enum {IDLE, SEND}, used for debug and assertions only.
- **Sub-module `prio_enc8x3`:** combinational first-set finder.
  - Inputs: `vec[7:0]` and `LSB_FIRST`.
  - Outputs: `idx[2:0]` and `any`.
  - This block instantiates it once.
  - It is also reusable by a testbench reference model.

## Test plan
- **Reset mid-burst:** load `req_in`=8'hFF, assert `rst_n`=0 after 3 codes → all outputs are 0 immediately; after release with no requests, `busy`=0.
- **Single request:** `enable`=1, `req_in`=8'b0000_0100 with `req_valid` for 1 cycle, `code_ready`=1 → `code_valid` is high for 1 cycle, 2 cycles later, with `code_out`=3'd2; then `busy`=0.
- **Multi-bit drain order:** `req_in`=8'b1010_0010 and `code_ready`=1 → codes 1, 5, 7 on consecutive cycles when `LSB_FIRST`=1; codes 7, 5, 1 when `LSB_FIRST`=0.
- **Backpressure:** `req_in`=8'h81 with `code_ready`=0 for 5 cycles → `code_out`=0 stable and `code_valid`=1, `pending`=8'h80. Raise `code_ready` → code 7 follows on the next cycle.
- **Duplicate and collision:**
  - Re-request 8'h80 while bit 7 is pending and not being loaded → `dup_err`=1, held until `err_clr`.
  - Re-request bit 3 on the same cycle bit 3 is loaded → `dup_err` unchanged and bit 3 is emitted twice.
- **Enable low:** with `pending`=8'h06 and code 1 in flight, drop `enable` → code 1 completes on ready, no further `code_valid`, and `pending`=8'h04 is retained. Raise `enable` → code 2 is emitted.
